// File: rtl/leds7_pkg.sv
// Shared constants, FSM state type, timeout sizing and segment table for the
// 7-segment command-frame controller.
package leds7_pkg;

  localparam logic [7:0] FRAME_HDR    = 8'hA5;
  localparam logic [3:0] OP_SET_DIGIT = 4'h1;
  localparam logic [3:0] OP_SET_BLANK = 4'h2;
  localparam logic [3:0] OP_CLEAR     = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    GET_CMD,
    GET_ARG,
    GET_CHK
  } state_t;

  // Timeout in clock cycles: timeout_bits * round(clk_freq[MHz]*1e6 / bit_rate).
  function automatic int calc_timeout(input int clk_freq, input int bit_rate,
                                      input int timeout_bits);
    longint cyc_per_bit;
    cyc_per_bit = (longint'(clk_freq) * longint'(1000000) + longint'(bit_rate / 2))
                  / longint'(bit_rate);
    return timeout_bits * int'(cyc_per_bit);
  endfunction

  // Active-high gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment (gfedcba) decoder.
module hex_to_seg7
  import leds7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Segments are lit by driving them low.
  assign seg = ~SEG_LUT[val];

endmodule

// File: rtl/leds7_cmd_ctrl.sv
// Parses A5/CMD/ARG/CHK frames from a UART byte stream, updates a digit bank
// and blank mask, and drives registered active-low 7-segment outputs.
module leds7_cmd_ctrl
  import leds7_pkg::*;
#(
  parameter int CLK_FREQ     = 50,
  parameter int BIT_RATE     = 115200,
  parameter int NUM_DIGITS   = 4,
  parameter int TIMEOUT_BITS = 30
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_err,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic [7:0]              err_cnt
);

  localparam int T  = calc_timeout(CLK_FREQ, BIT_RATE, TIMEOUT_BITS);
  localparam int TW = (T > 1) ? $clog2(T) : 1;

  state_t                  state_reg, state_next;
  logic [7:0]              cmd_reg, cmd_next;
  logic [7:0]              arg_reg, arg_next;
  logic [TW-1:0]           tmo_reg, tmo_next;
  logic [3:0]              digit_reg [NUM_DIGITS];
  logic [3:0]              digit_next [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic                    ok_next, err_next;
  logic                    cmd_legal;
  logic                    tmo_hit;

  // Frame parser: rx_err beats a byte, a byte beats the timeout.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    arg_next   = arg_reg;
    tmo_next   = tmo_reg;
    digit_next = digit_reg;
    blank_next = blank_reg;
    ok_next    = 1'b0;
    err_next   = 1'b0;
    tmo_hit    = (tmo_reg == TW'(T - 1));

    case (cmd_reg[7:4])
      OP_SET_DIGIT:           cmd_legal = (int'(cmd_reg[1:0]) < NUM_DIGITS);
      OP_SET_BLANK, OP_CLEAR: cmd_legal = 1'b1;
      default:                cmd_legal = 1'b0;
    endcase

    if (state_reg == IDLE) begin
      tmo_next = '0;
      if (rx_valid && !rx_err && rx_data == FRAME_HDR)
        state_next = GET_CMD;
    end else if (rx_err || (!rx_valid && tmo_hit)) begin
      err_next   = 1'b1;
      state_next = IDLE;
      tmo_next   = '0;
    end else if (rx_valid) begin
      tmo_next = '0;
      case (state_reg)
        GET_CMD: begin
          cmd_next   = rx_data;
          state_next = GET_ARG;
        end
        GET_ARG: begin
          arg_next   = rx_data;
          state_next = GET_CHK;
        end
        default: begin
          state_next = IDLE;
          if (rx_data == (FRAME_HDR ^ cmd_reg ^ arg_reg) && cmd_legal) begin
            ok_next = 1'b1;
            case (cmd_reg[7:4])
              OP_SET_DIGIT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (cmd_reg[1:0] == 2'(i)) begin
                    digit_next[i] = arg_reg[3:0];
                    blank_next[i] = 1'b0;
                  end
                end
              end
              OP_SET_BLANK: blank_next = arg_reg[NUM_DIGITS-1:0];
              default: begin
                digit_next = '{default: '0};
                blank_next = '0;
              end
            endcase
          end else begin
            err_next = 1'b1;
          end
        end
      endcase
    end else begin
      tmo_next = tmo_reg + TW'(1);
    end
  end

  // Decode the next digit values so hex updates together with frame_ok.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    logic [6:0] seg;
    hex_to_seg7 u_dec (
      .val(digit_next[gi]),
      .seg(seg)
    );
    assign hex_next[gi*7 +: 7] = blank_next[gi] ? 7'h7F : seg;
  end

  // State, frame fields, display bank, registered outputs and error counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cmd_reg   <= '0;
      arg_reg   <= '0;
      tmo_reg   <= '0;
      digit_reg <= '{default: '0};
      blank_reg <= '1;
      hex       <= '1;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      arg_reg   <= arg_next;
      tmo_reg   <= tmo_next;
      digit_reg <= digit_next;
      blank_reg <= blank_next;
      hex       <= hex_next;
      frame_ok  <= ok_next;
      frame_err <= err_next;
      if (err_next && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_leds7_cmd_ctrl.sv
// Scoreboard bench for leds7_cmd_ctrl: the driver pushes expected frame
// outcomes from a digit/blank model; a negedge monitor pops and compares.
module tb_leds7_cmd_ctrl;

  localparam int ND = 4;
  localparam int T  = 13020;   // 30 bit periods * 434 cycles per bit

  logic          clk = 1'b0;
  logic          resetn;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_err;
  logic [27:0]   hex;
  logic          frame_ok;
  logic          frame_err;
  logic [7:0]    err_cnt;

  leds7_cmd_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err),
    .hex      (hex),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         ok;
    int         due;
    logic [27:0] hex;
    logic [7:0] cnt;
  } exp_t;
  exp_t q[$];

  // Reference display state
  logic [6:0] seg_on [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int       m_digit [ND];
  bit [3:0] m_blank = 4'hF;
  int       m_err = 0;

  logic [27:0] cur_hex = 28'hFFFFFFF;
  logic [7:0]  cur_cnt = 8'h00;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [27:0] model_hex();
    logic [27:0] h;
    for (int i = 0; i < ND; i++)
      h[i*7 +: 7] = m_blank[i] ? 7'h7F : ~seg_on[m_digit[i]];
    return h;
  endfunction

  task automatic model_apply(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] k, output bit ok);
    ok = 1'b0;
    if (k == (8'hA5 ^ c ^ a)) begin
      if (c[7:4] == 4'h1 && int'(c[1:0]) < ND) begin
        m_digit[c[1:0]] = int'(a[3:0]);
        m_blank[c[1:0]] = 1'b0;
        ok = 1'b1;
      end else if (c[7:4] == 4'h2) begin
        m_blank = a[3:0];
        ok = 1'b1;
      end else if (c[7:4] == 4'h3) begin
        for (int i = 0; i < ND; i++) m_digit[i] = 0;
        m_blank = 4'h0;
        ok = 1'b1;
      end
    end
  endtask

  task automatic push_exp(input bit ok, input int due);
    exp_t e;
    if (!ok && m_err < 255) m_err++;
    e.ok  = ok;
    e.due = due;
    e.hex = model_hex();
    e.cnt = 8'(m_err);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_err(input bit with_byte, input logic [7:0] b);
    rx_err   = 1'b1;
    rx_valid = with_byte;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_err   = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] k, input int maxgap);
    bit ok;
    send_byte(8'hA5); idle($urandom_range(0, maxgap));
    send_byte(c);     idle($urandom_range(0, maxgap));
    send_byte(a);     idle($urandom_range(0, maxgap));
    send_byte(k);
    model_apply(c, a, k, ok);
    push_exp(ok, cyc);
    $display("frame %02h %02h %02h %02h -> %s", 8'hA5, c, a, k, ok ? "ok" : "err");
  endtask

  // Monitor: every cycle compare hex/err_cnt against the last committed
  // expectation; on a frame pulse pop the scoreboard and check timing/content.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_event actual=none expected=%s due %0d", q[0].ok ? "ok" : "err", q[0].due);
        cur_hex = q[0].hex;
        cur_cnt = q[0].cnt;
        void'(q.pop_front());
      end
      if (frame_ok || frame_err) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=ok%0b/err%0b expected=none at cycle %0d", frame_ok, frame_err, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          cur_hex = e.hex;
          cur_cnt = e.cnt;
          chk("event_ok",   32'(frame_ok),  32'(e.ok));
          chk("event_err",  32'(frame_err), 32'(!e.ok));
          chk("event_cycle", 32'(cyc),      32'(e.due));
          $display("event %s cycle %0d hex %07h cnt %0d", frame_ok ? "ok" : "err", cyc, hex, err_cnt);
        end
      end
      chk("hex", 32'(hex), 32'(cur_hex));
      chk("err_cnt", 32'(err_cnt), 32'(cur_cnt));
    end
  end

  initial begin
    logic [7:0] c, a, k, g;
    int         kind;
    int         t0;
    resetn   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_err   = 1'b0;
    for (int i = 0; i < ND; i++) m_digit[i] = 0;
    idle(3);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_hex", 32'(hex), 32'h0FFFFFFF);
    chk("reset_err_cnt", 32'(err_cnt), 32'h0);
    chk("reset_pulses", 32'({frame_ok, frame_err}), 32'h0);
    mon_en = 1'b1;
    idle(2);

    // Digit 2 shows '5'
    send_frame(8'h12, 8'h05, 8'hB2, 0);
    idle(2);
    chk("digit2_seg", 32'(hex[20:14]), 32'h12);
    // Clear, then a bad checksum
    send_frame(8'h30, 8'h00, 8'h95, 1);
    send_frame(8'h12, 8'h05, 8'hB3, 1);
    idle(2);

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h12);
    push_exp(1'b0, cyc + T);
    $display("timeout armed at cycle %0d", cyc);
    idle(T + 3);
    send_frame(8'h20, 8'h00, 8'h85, 0);

    // Byte arriving exactly on the expiry cycle wins over the timeout
    send_byte(8'hA5);
    send_byte(8'h13);
    idle(T - 1);
    send_byte(8'h07);
    send_byte(8'hA5 ^ 8'h13 ^ 8'h07);
    begin
      bit ok;
      model_apply(8'h13, 8'h07, 8'hA5 ^ 8'h13 ^ 8'h07, ok);
      push_exp(ok, cyc);
      $display("late-byte frame -> %s", ok ? "ok" : "err");
    end

    // rx_err between CMD and ARG, then a good frame
    send_byte(8'hA5);
    send_byte(8'h30);
    send_err(1'b0, 8'h00);
    push_exp(1'b0, cyc);
    send_frame(8'h30, 8'h00, 8'h95, 0);

    // rx_err together with a byte mid-frame: aborted
    send_byte(8'hA5);
    send_byte(8'h11);
    send_err(1'b1, 8'h09);
    push_exp(1'b0, cyc);
    // rx_err in IDLE ignored; header carried with rx_err is dropped
    send_err(1'b0, 8'h00);
    send_err(1'b1, 8'hA5);
    send_byte(8'h12); send_byte(8'h05); send_byte(8'hB2);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 6);
      c = 8'($urandom);
      a = 8'($urandom);
      case (kind)
        0, 1: c = {4'h1, c[3:0]};
        2:    c = {4'h2, c[3:0]};
        3:    c = {4'h3, c[3:0]};
        default: ;
      endcase
      k = 8'hA5 ^ c ^ a;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 5) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
        $display("idle garbage %02h", g);
      end else if (kind == 6) begin
        send_byte(8'hA5);
        if ($urandom_range(0, 1) == 1) send_byte(c);
        send_err(1'b0, 8'h00);
        push_exp(1'b0, cyc);
        $display("rx_err abort");
      end else begin
        send_frame(c, a, k, 2);
      end
      idle($urandom_range(0, 2));
    end

    // Error counter saturation
    for (int n = 0; n < 300; n++) begin
      send_frame(8'h12, 8'h05, 8'h00, 0);
      idle(1);
    end
    idle(2);
    chk("err_cnt_saturated", 32'(err_cnt), 32'hFF);

    // Drain the scoreboard with a bounded wait
    t0 = cyc;
    while (q.size() > 0 && cyc - t0 < 50) idle(1);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
